// File: rtl/rider_steer_enable.sv
// Rider-presence / steering-enable controller: OFF -> WAIT (settle timer) -> STEER.
// Optional macro RIDER_OFF_DEBOUNCE_EN: the drop to OFF needs 4 consecutive low-weight samples.
`timescale 1ns/1ps
module rider_steer_enable #(
  parameter int unsigned FAST_SIM     = 0,
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off,
  output logic [1:0]  state_dbg
);

  localparam int unsigned LD_W  = 12;
  localparam int unsigned SUM_W = LD_W + 1;
  localparam int unsigned TMR_W = (FAST_SIM != 0) ? 15 : 26;
  localparam logic [SUM_W-1:0] ENTER_THR = SUM_W'(MIN_RIDER_WT) + SUM_W'(WT_HYST);
  localparam logic [SUM_W-1:0] STAY_THR  = SUM_W'(MIN_RIDER_WT) - SUM_W'(WT_HYST);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  state_t            state, nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [LD_W-1:0]   lft_q, rght_q;
  logic [SUM_W-1:0]  sum;
  logic [LD_W-1:0]   diff;
  logic              sum_gt_enter, sum_gt_stay, diff_gt_1_4, diff_gt_15_16;
  logic              tmr_full, exit_off, hold_low;

  // Load-cell capture; decisions only ever look at the latched pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else if (vld) begin
      lft_q  <= lft_ld;
      rght_q <= rght_ld;
    end
  end

  always_comb begin
    sum  = SUM_W'(lft_q) + SUM_W'(rght_q);
    diff = (lft_q > rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
  end

  assign sum_gt_enter  = sum > ENTER_THR;
  assign sum_gt_stay   = sum > STAY_THR;
  assign diff_gt_1_4   = SUM_W'(diff) > (sum >> 2);
  assign diff_gt_15_16 = SUM_W'(diff) > (sum - (sum >> 4));
  assign tmr_full      = &tmr;

`ifdef RIDER_OFF_DEBOUNCE_EN
  logic       smp_q;
  logic [1:0] low_cnt;

  // smp_q marks the cycle in which the latched pair is a fresh sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q   <= 1'b0;
      low_cnt <= '0;
    end else begin
      smp_q <= vld;
      if (state == OFF) begin
        low_cnt <= '0;
      end else if (smp_q) begin
        if (sum_gt_stay)          low_cnt <= '0;
        else if (low_cnt != 2'd3) low_cnt <= low_cnt + 2'd1;
      end
    end
  end

  assign exit_off = smp_q && !sum_gt_stay && (low_cnt == 2'd3);
  assign hold_low = !sum_gt_stay;
`else
  assign exit_off = !sum_gt_stay;
  assign hold_low = 1'b0;
`endif

  // Next-state and timer; step-off outranks imbalance and timer expiry
  always_comb begin
    nxt     = state;
    tmr_nxt = tmr;
    case (state)
      OFF: begin
        if (sum_gt_enter) nxt = WAIT;
      end
      WAIT: begin
        if (exit_off)                  nxt = OFF;
        else if (diff_gt_1_4)          tmr_nxt = '0;
        else if (tmr_full && !hold_low) nxt = STEER;
        else if (!tmr_full)            tmr_nxt = tmr + TMR_W'(1);
      end
      STEER: begin
        if (exit_off)           nxt = OFF;
        else if (diff_gt_15_16) nxt = WAIT;
      end
      default: nxt = OFF;
    endcase
    if (nxt != WAIT || state != WAIT) tmr_nxt = (state == WAIT && nxt == WAIT) ? tmr_nxt : '0;
  end

  // Outputs are registered decodes of the next state, so they move with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OFF;
      tmr       <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
      state_dbg <= 2'd0;
    end else begin
      state     <= nxt;
      tmr       <= tmr_nxt;
      en_steer  <= (nxt == STEER);
      rider_off <= (nxt == OFF);
      state_dbg <= nxt;
    end
  end

endmodule

// File: tb/tb_rider_steer_enable.sv
// Self-checking bench for rider_steer_enable (FAST_SIM=1) against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_rider_steer_enable;

  localparam int ENTER = 576;
  localparam int STAY  = 448;
  localparam int TMAX  = 32767;
  localparam int FULL_WAIT = TMAX + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [11:0] lft, rght;
  logic        en_steer, rider_off;
  logic [1:0]  state_dbg;

  int nchk = 0;
  int nerr = 0;

  int m_state, m_tmr, m_l, m_r, m_run;
  bit m_fresh;

  rider_steer_enable #(.FAST_SIM(1)) dut (
    .clk(clk), .rst(rst), .vld(vld), .lft_ld(lft), .rght_ld(rght),
    .en_steer(en_steer), .rider_off(rider_off), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state = 0; m_tmr = 0; m_l = 0; m_r = 0; m_run = 0; m_fresh = 0;
  endtask

  // One clock of the specified behaviour, using the pair latched before this edge
  task automatic model_step();
    int sum, diff, nst;
    bit low, ext;
    if (rst) return;
    sum  = m_l + m_r;
    diff = (m_l > m_r) ? m_l - m_r : m_r - m_l;
    low  = !(sum > STAY);
`ifdef RIDER_OFF_DEBOUNCE_EN
    ext = low && m_fresh && (m_run >= 3);
`else
    ext = low;
`endif
    nst = m_state;
    case (m_state)
      0: if (sum > ENTER) begin nst = 1; m_tmr = 0; end
      1: begin
        if (ext) nst = 0;
        else if (diff > sum / 4) m_tmr = 0;
`ifdef RIDER_OFF_DEBOUNCE_EN
        else if (m_tmr == TMAX && !low) nst = 2;
`else
        else if (m_tmr == TMAX) nst = 2;
`endif
        else if (m_tmr < TMAX) m_tmr++;
      end
      2: begin
        if (ext) nst = 0;
        else if (diff > sum - sum / 16) begin nst = 1; m_tmr = 0; end
      end
      default: nst = 0;
    endcase
    if (m_state == 0) m_run = 0;
    else if (m_fresh) m_run = low ? ((m_run < 3) ? m_run + 1 : 3) : 0;
    m_state = nst;
    m_fresh = vld;
    if (vld) begin m_l = int'(lft); m_r = int'(rght); end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [11:0] l, input logic [11:0] r);
    lft = l; rght = r; vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; lft = 12'($urandom); rght = 12'($urandom);
    repeat (2) @(negedge clk);
    nchk++;
    if (en_steer !== 1'b0 || rider_off !== 1'b1 || state_dbg !== 2'd0) begin
      nerr++; $display("FAIL reset_state got en=%b off=%b st=%0d exp en=0 off=1 st=0", en_steer, rider_off, state_dbg);
    end
    rst = 1'b0;
    model_reset();
    lft = 12'h300; rght = 12'h300;
    repeat (5) tick();
    nchk++;
    if (state_dbg !== 2'd0 || rider_off !== 1'b1) begin
      nerr++; $display("FAIL no_vld_ignored got st=%0d off=%b exp st=0 off=1", state_dbg, rider_off);
    end
  endtask

  task automatic test_enter_wait();
    send(12'h300, 12'h300);
    nchk++;
    if (state_dbg !== 2'd0) begin nerr++; $display("FAIL enter_latency1 got st=%0d exp 0", state_dbg); end
    tick();
    nchk++;
    if (state_dbg !== 2'd1 || rider_off !== 1'b0 || en_steer !== 1'b0) begin
      nerr++; $display("FAIL enter_wait got st=%0d off=%b en=%b exp st=1 off=0 en=0", state_dbg, rider_off, en_steer);
    end
  endtask

  task automatic test_imbalance_wait();
    int n; bit bad;
    for (int i = 0; i < 12; i++) begin
      send(12'h300, 12'($urandom_range(0, 256)));
      repeat ($urandom_range(0, 40)) tick();
      nchk++;
      if (state_dbg !== 2'd1 || en_steer !== 1'b0 || m_state != 1) begin
        nerr++; $display("FAIL imbalance_wait got st=%0d en=%b model=%0d exp st=1 en=0", state_dbg, en_steer, m_state);
      end
    end
    send(12'h200, 12'h200);
    n = 0; bad = 0;
    while (m_state != 2 && n < 40000) begin
      tick(); n++;
      if (state_dbg !== 2'(m_state)) bad = 1;
    end
    nchk++;
    if (bad || en_steer !== 1'b1 || state_dbg !== 2'd2 || n != FULL_WAIT) begin
      nerr++; $display("FAIL settle_after_imbalance got cycles=%0d en=%b st=%0d diverged=%0d exp cycles=%0d en=1 st=2", n, en_steer, state_dbg, bad, FULL_WAIT);
    end
  endtask

  task automatic test_steer_hysteresis();
    int l;
    send(12'd250, 12'd250);
    repeat (3) tick();
    nchk++;
    if (state_dbg !== 2'd2 || en_steer !== 1'b1) begin
      nerr++; $display("FAIL steer_sum500 got st=%0d en=%b exp st=2 en=1", state_dbg, en_steer);
    end
    for (int i = 0; i < 10; i++) begin
      l = $urandom_range(300, 2000);
      send(12'(l), 12'(l + $urandom_range(0, 100) - 50));
      repeat ($urandom_range(1, 6)) tick();
      nchk++;
      if (state_dbg !== 2'(m_state) || m_state != 2 || en_steer !== 1'b1) begin
        nerr++; $display("FAIL steer_random got st=%0d en=%b exp st=%0d en=1", state_dbg, en_steer, m_state);
      end
    end
  endtask

  task automatic test_gross_imbalance();
    send(12'h3F0, 12'h008);
    nchk++;
    if (en_steer !== 1'b1) begin nerr++; $display("FAIL gross_latency1 got en=%b exp 1", en_steer); end
    tick();
    nchk++;
    if (state_dbg !== 2'd1 || en_steer !== 1'b0 || rider_off !== 1'b0) begin
      nerr++; $display("FAIL gross_to_wait got st=%0d en=%b off=%b exp st=1 en=0 off=0", state_dbg, en_steer, rider_off);
    end
  endtask

  task automatic test_reset_mid_wait();
    send(12'h200, 12'h200);
    repeat (1000) tick();
    nchk++;
    if (state_dbg !== 2'd1) begin nerr++; $display("FAIL pre_reset_wait got st=%0d exp 1", state_dbg); end
    #2 rst = 1'b1;
    #1;
    nchk++;
    if (state_dbg !== 2'd0 || rider_off !== 1'b1 || en_steer !== 1'b0) begin
      nerr++; $display("FAIL async_reset got st=%0d off=%b en=%b exp st=0 off=1 en=0", state_dbg, rider_off, en_steer);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_off_hysteresis();
    int n; bit bad;
    send(12'd250, 12'd250);
    repeat (4) tick();
    nchk++;
    if (state_dbg !== 2'd0 || rider_off !== 1'b1) begin
      nerr++; $display("FAIL off_sum500 got st=%0d off=%b exp st=0 off=1", state_dbg, rider_off);
    end
    send(12'd289, 12'd288);
    tick();
    nchk++;
    if (state_dbg !== 2'd1 || rider_off !== 1'b0) begin
      nerr++; $display("FAIL off_sum577 got st=%0d off=%b exp st=1 off=0", state_dbg, rider_off);
    end
    n = 0; bad = 0;
    while (m_state != 2 && n < 40000) begin
      tick(); n++;
      if (state_dbg !== 2'(m_state)) bad = 1;
    end
    nchk++;
    if (bad || en_steer !== 1'b1 || n != FULL_WAIT) begin
      nerr++; $display("FAIL full_wait_after_reset got cycles=%0d en=%b diverged=%0d exp cycles=%0d en=1", n, en_steer, bad, FULL_WAIT);
    end
  endtask

  task automatic test_step_off();
`ifdef RIDER_OFF_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) begin
      send(12'h0E0, 12'h0E0);
      repeat (2) tick();
    end
    send(12'h300, 12'h300);
    repeat (2) tick();
    nchk++;
    if (state_dbg !== 2'd2 || en_steer !== 1'b1) begin
      nerr++; $display("FAIL debounce_hold got st=%0d en=%b exp st=2 en=1", state_dbg, en_steer);
    end
    for (int i = 0; i < 3; i++) begin
      send(12'h0E0, 12'h0E0);
      repeat (2) tick();
    end
    nchk++;
    if (state_dbg !== 2'd2) begin nerr++; $display("FAIL debounce_3low got st=%0d exp 2", state_dbg); end
`endif
    send(12'h0E0, 12'h0E0);
    nchk++;
    if (state_dbg !== 2'd2) begin nerr++; $display("FAIL stepoff_latency1 got st=%0d exp 2", state_dbg); end
    tick();
    nchk++;
    if (state_dbg !== 2'd0 || rider_off !== 1'b1 || en_steer !== 1'b0) begin
      nerr++; $display("FAIL step_off got st=%0d off=%b en=%b exp st=0 off=1 en=0", state_dbg, rider_off, en_steer);
    end
  endtask

  task automatic test_random();
    int l, r, kind;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        kind = $urandom_range(0, 2);
        l = $urandom_range(0, 4095);
        case (kind)
          0: r = $urandom_range(0, 4095);
          1: begin l = $urandom_range(200, 320); r = l + $urandom_range(0, 20) - 10; end
          default: r = l + $urandom_range(0, 40) - 20;
        endcase
        if (r < 0) r = 0;
        if (r > 4095) r = 4095;
        send(12'(l), 12'(r));
      end else begin
        lft = 12'($urandom); rght = 12'($urandom);
        tick();
      end
      nchk++;
      if (state_dbg !== 2'(m_state) || en_steer !== (m_state == 2) || rider_off !== (m_state == 0)) begin
        nerr++; $display("FAIL random_cycle%0d got st=%0d en=%b off=%b exp st=%0d", i, state_dbg, en_steer, rider_off, m_state);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_enter_wait();
    test_imbalance_wait();
    test_steer_hysteresis();
    test_gross_imbalance();
    test_reset_mid_wait();
    test_off_hysteresis();
    test_step_off();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
